// File: rtl/cond_code_unit.sv
// Condition-code flag register plus branch-condition evaluator; one cycle from request to cnd/cnd_valid.
// stall freezes every register; exc_kill only suppresses the flag write.
module cond_code_unit #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [SIZE-1:0] alu_y,
    input  logic            alu_error,
    input  logic            alu_carry,
    input  logic            set_cc,
    input  logic            stall,
    input  logic            exc_kill,
    input  logic            cond_req,
    input  logic [3:0]      ifun,
    output logic            zf,
    output logic            sf,
    output logic            of,
    output logic            cf,
    output logic            cnd,
    output logic            cnd_valid,
    output logic            cc_err
);

    logic r_zf, r_sf, r_of, r_cf;
    logic r_cnd, r_cnd_valid, r_cc_err;

    logic w_cc_we;
    logic w_lt;
    logic w_cnd;
    logic w_illegal;

    assign w_cc_we = alu_valid & set_cc & ~stall & ~exc_kill;
    assign w_lt    = r_sf ^ r_of;

    // Evaluation always reads the registered flags, so a same-cycle write is not bypassed.
    always_comb begin
        w_cnd     = 1'b0;
        w_illegal = 1'b0;
        case (ifun)
            4'd0:    w_cnd = 1'b1;
            4'd1:    w_cnd = w_lt | r_zf;
            4'd2:    w_cnd = w_lt;
            4'd3:    w_cnd = r_zf;
            4'd4:    w_cnd = ~r_zf;
            4'd5:    w_cnd = ~w_lt;
            4'd6:    w_cnd = ~w_lt & ~r_zf;
            default: w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf        <= 1'b1;
            r_sf        <= 1'b0;
            r_of        <= 1'b0;
            r_cf        <= 1'b0;
            r_cnd       <= 1'b0;
            r_cnd_valid <= 1'b0;
            r_cc_err    <= 1'b0;
        end else if (!stall) begin
            if (w_cc_we) begin
                r_zf <= (alu_y == '0);
                r_sf <= alu_y[SIZE-1];
                r_of <= alu_error;
                r_cf <= alu_carry;
            end
            r_cnd_valid <= cond_req;
            if (cond_req) begin
                r_cnd    <= w_cnd;
                r_cc_err <= w_illegal;
            end else begin
                r_cc_err <= 1'b0;
            end
        end
    end

    assign zf        = r_zf;
    assign sf        = r_sf;
    assign of        = r_of;
    assign cf        = r_cf;
    assign cnd       = r_cnd;
    assign cnd_valid = r_cnd_valid;
    assign cc_err    = r_cc_err;

endmodule

// File: tb/tb_cond_code_unit.sv
// Bench for cond_code_unit: directed vector table followed by a randomized run against a reference model.
// Output vector order everywhere: {zf, sf, of, cf, cnd, cnd_valid, cc_err}.
module tb_cond_code_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [63:0] alu_y;
    logic        alu_error;
    logic        alu_carry;
    logic        set_cc;
    logic        stall;
    logic        exc_kill;
    logic        cond_req;
    logic [3:0]  ifun;
    logic        zf, sf, of, cf, cnd, cnd_valid, cc_err;

    cond_code_unit #(.SIZE(64)) dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_y(alu_y),
        .alu_error(alu_error), .alu_carry(alu_carry), .set_cc(set_cc),
        .stall(stall), .exc_kill(exc_kill), .cond_req(cond_req), .ifun(ifun),
        .zf(zf), .sf(sf), .of(of), .cf(cf), .cnd(cnd),
        .cnd_valid(cnd_valid), .cc_err(cc_err)
    );

    always #5 clk = ~clk;

    // ctl = {rst, alu_valid, set_cc, alu_error, alu_carry, stall, exc_kill, cond_req}
    typedef struct {
        logic [7:0]  ctl;
        logic [63:0] y;
        logic [3:0]  fn;
        logic [6:0]  exp;
    } vec_t;

    typedef struct {
        logic [6:0] exp;
        int         id;
    } sb_t;

    vec_t vecs[31];
    sb_t  sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model state
    logic m_zf, m_sf, m_of, m_cf, m_cnd, m_v, m_e;

    function automatic vec_t mk(input logic [7:0] c, input logic [63:0] y,
                                input logic [3:0] f, input logic [6:0] e);
        vec_t v;
        v.ctl = c; v.y = y; v.fn = f; v.exp = e;
        return v;
    endfunction

    task automatic apply(input logic [7:0] c, input logic [63:0] y,
                         input logic [3:0] f, input logic [6:0] e, input int id);
        sb_t s;
        logic [6:0] act;
        @(negedge clk);
        {rst, alu_valid, set_cc, alu_error, alu_carry, stall, exc_kill, cond_req} = c;
        alu_y = y;
        ifun  = f;
        sb_q.push_back('{exp: e, id: id});
        @(posedge clk);
        #1;
        s   = sb_q.pop_front();
        act = {zf, sf, of, cf, cnd, cnd_valid, cc_err};
        tests_run++;
        if (act !== s.exp) begin
            tests_failed++;
            $display("FAIL vec%0d: got {zf,sf,of,cf,cnd,vld,err}=%b expected %b", s.id, act, s.exp);
        end
    endtask

    function automatic logic [6:0] model_step(input logic [7:0] c, input logic [63:0] y,
                                              input logic [3:0] f);
        logic r, av, sc, er, ca, st, kl, rq;
        logic lt, cres, ill;
        {r, av, sc, er, ca, st, kl, rq} = c;
        lt   = m_sf ^ m_of;
        ill  = (f > 4'd6);
        cres = 1'b0;
        if (f == 4'd0) cres = 1'b1;
        if (f == 4'd1) cres = lt | m_zf;
        if (f == 4'd2) cres = lt;
        if (f == 4'd3) cres = m_zf;
        if (f == 4'd4) cres = !m_zf;
        if (f == 4'd5) cres = !lt;
        if (f == 4'd6) cres = !lt && !m_zf;
        if (r) begin
            {m_zf, m_sf, m_of, m_cf, m_cnd, m_v, m_e} = 7'b1000000;
        end else if (!st) begin
            if (av && sc && !kl) begin
                m_zf = (y == 64'd0);
                m_sf = y[63];
                m_of = er;
                m_cf = ca;
            end
            m_v = rq;
            m_e = rq && ill;
            if (rq) m_cnd = ill ? 1'b0 : cres;
        end
        return {m_zf, m_sf, m_of, m_cf, m_cnd, m_v, m_e};
    endfunction

    initial begin
        logic [63:0] ones;
        ones = '1;
        {rst, alu_valid, set_cc, alu_error, alu_carry, stall, exc_kill, cond_req} = 8'h80;
        alu_y = '0;
        ifun  = '0;

        vecs[0]  = mk(8'b1000_0000, 64'd0, 4'd0, 7'b1000000);
        vecs[1]  = mk(8'b0000_0001, 64'd0, 4'd3, 7'b1000110);
        vecs[2]  = mk(8'b0000_0000, 64'd0, 4'd0, 7'b1000100);
        vecs[3]  = mk(8'b0111_0000, 64'h8000_0000_0000_0000, 4'd0, 7'b0110100);
        vecs[4]  = mk(8'b0000_0001, 64'd0, 4'd2, 7'b0110010);
        vecs[5]  = mk(8'b0000_0001, 64'd0, 4'd1, 7'b0110010);
        vecs[6]  = mk(8'b0000_0001, 64'd0, 4'd5, 7'b0110110);
        vecs[7]  = mk(8'b0000_0001, 64'd0, 4'd6, 7'b0110110);
        vecs[8]  = mk(8'b0000_0001, 64'd0, 4'd4, 7'b0110110);
        vecs[9]  = mk(8'b0000_0001, 64'd0, 4'd0, 7'b0110110);
        vecs[10] = mk(8'b0110_1001, 64'd0, 4'd3, 7'b1001010);
        vecs[11] = mk(8'b0000_0001, 64'd0, 4'd3, 7'b1001110);
        vecs[12] = mk(8'b0110_0101, 64'd5, 4'd9, 7'b1001110);
        vecs[13] = mk(8'b0110_0101, 64'd5, 4'd9, 7'b1001110);
        vecs[14] = mk(8'b0110_0101, 64'd5, 4'd9, 7'b1001110);
        vecs[15] = mk(8'b0000_0000, 64'd0, 4'd0, 7'b1001100);
        vecs[16] = mk(8'b0110_0011, ones, 4'd9, 7'b1001011);
        vecs[17] = mk(8'b0011_1001, ones, 4'd15, 7'b1001011);
        vecs[18] = mk(8'b0000_0000, 64'd0, 4'd0, 7'b1001000);
        vecs[19] = mk(8'b0111_0001, 64'd1, 4'd2, 7'b0010010);
        vecs[20] = mk(8'b0000_0001, 64'd0, 4'd2, 7'b0010110);
        vecs[21] = mk(8'b0000_0001, 64'd0, 4'd1, 7'b0010110);
        vecs[22] = mk(8'b0000_0001, 64'd0, 4'd6, 7'b0010010);
        vecs[23] = mk(8'b0000_0001, 64'd0, 4'd7, 7'b0010011);
        vecs[24] = mk(8'b0000_0001, 64'd0, 4'd8, 7'b0010011);
        vecs[25] = mk(8'b0000_0001, 64'd0, 4'd0, 7'b0010110);
        vecs[26] = mk(8'b1110_1001, 64'd0, 4'd3, 7'b1000000);
        vecs[27] = mk(8'b0110_0000, ones, 4'd0, 7'b0100000);
        vecs[28] = mk(8'b0000_0001, 64'd0, 4'd0, 7'b0100110);
        vecs[29] = mk(8'b1000_0101, 64'd0, 4'd0, 7'b1000000);
        vecs[30] = mk(8'b0000_0001, 64'd0, 4'd3, 7'b1000110);

        for (int i = 0; i < 31; i++)
            apply(vecs[i].ctl, vecs[i].y, vecs[i].fn, vecs[i].exp, i);

        // Randomized run: model state continues from the last directed vector.
        {m_zf, m_sf, m_of, m_cf, m_cnd, m_v, m_e} = 7'b1000110;
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  c;
            logic [63:0] y;
            logic [3:0]  f;
            logic [6:0]  e;
            c    = 8'($urandom);
            c[7] = ($urandom_range(0, 31) == 0);
            c[2] = ($urandom_range(0, 4) == 0);
            y    = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) y = 64'd0;
            f    = 4'($urandom_range(0, 9));
            e    = model_step(c, y, f);
            apply(c, y, f, e, 100 + i);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cond_code_unit.md
COND_CODE_UNIT -- requirements
Module: cond_code_unit

Interface
REQ-001 SHALL have parameter SIZE, default 64, data width of the ALU result consumed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port alu_valid  input  1  ALU result/flags valid this cycle.
REQ-005 SHALL have port alu_y  input  SIZE  signed ALU result.
REQ-006 SHALL have port alu_error  input  1  ALU signed-overflow indication.
REQ-007 SHALL have port alu_carry  input  1  ALU carry/borrow indication.
REQ-008 SHALL have port set_cc  input  1  current instruction is an OPq; condition codes are to be written.
REQ-009 SHALL have port stall  input  1  freeze: hold all state, ignore requests.
REQ-010 SHALL have port exc_kill  input  1  later-stage exception; suppress the CC write.
REQ-011 SHALL have port cond_req  input  1  request evaluation of the condition selected by ifun.
REQ-012 SHALL have port ifun  input  4  condition function code.
REQ-013 SHALL have port zf, sf, of, cf  output  1 each  registered condition flags.
REQ-014 SHALL have port cnd  output  1  registered condition result.
REQ-015 SHALL have port cnd_valid  output  1  cnd valid this cycle.
REQ-016 SHALL have port cc_err  output  1  the evaluated ifun was illegal.

Function
REQ-017 SHALL define cc_we = alu_valid & set_cc & ~stall & ~exc_kill.
REQ-018 SHALL, when cc_we=1, load on the next edge: zf = (alu_y == 0), sf = alu_y[SIZE-1], of = alu_error, cf = alu_carry.
REQ-019 SHALL hold all four flags unchanged when cc_we=0.
REQ-020 SHALL, when cond_req=1 and stall=0, set cnd_valid=1 on the next edge, with cnd computed from the flag values registered before that edge.
REQ-021 SHALL make a CC write and an evaluation in the same cycle use the old flags; the new flags are visible to requests from the following cycle on, with no bypass.
REQ-022 SHALL compute cnd per ifun as follows:
- 0 (always): 1
- 1 (le): (sf^of)|zf
- 2 (l): sf^of
- 3 (e): zf
- 4 (ne): ~zf
- 5 (ge): ~(sf^of)
- 6 (g): ~(sf^of)&~zf
REQ-023 SHALL, for ifun 7..15 with an accepted cond_req, register cnd=0, cc_err=1, cnd_valid=1.
REQ-024 SHALL register cc_err=0 for any accepted request with a legal ifun.
REQ-025 SHALL, on a cycle with stall=0 and cond_req=0, register cnd_valid=0 and cc_err=0 on the next edge, with cnd holding its last value.
REQ-026 SHALL, when stall=1, hold flags, cnd, cnd_valid and cc_err exactly, regardless of every other input.
REQ-027 SHALL treat cnd_valid as a one-cycle pulse per accepted request; back-to-back requests give back-to-back pulses, one cycle of latency each.
REQ-028 SHALL let exc_kill block only the CC write; evaluation in that cycle proceeds normally.
REQ-029 SHALL ignore alu_y, alu_error and alu_carry whenever alu_valid=0.

Reset
REQ-030 SHALL, when rst=1 at an edge, set zf=1, sf=0, of=0, cf=0, cnd=0, cnd_valid=0, cc_err=0, overriding stall, cc_we and cond_req.
REQ-031 SHALL discard any CC write or request presented in the reset cycle, including a reset asserted mid-sequence; outputs take reset values one edge after rst is sampled high.

Verification
REQ-032 SHALL be checked with: reset, then cond_req, ifun=3 -> next cycle cnd=1, cnd_valid=1 (reset zf=1).
REQ-033 SHALL be checked with: alu_valid=1, set_cc=1, alu_y=0x8000000000000000, alu_error=1 -> sf=1, of=1, zf=0; then ifun=2 -> cnd=0; ifun=1 -> cnd=0; ifun=5 -> cnd=1.
REQ-034 SHALL be checked with: CC write of alu_y=0 together with cond_req ifun=3 while zf=0 -> cnd=0; a repeated request the next cycle -> cnd=1.
REQ-035 SHALL be checked with: stall=1 for 3 cycles with a CC write of alu_y=5 and cond_req asserted -> flags, cnd, cnd_valid and cc_err unchanged throughout.
REQ-036 SHALL be checked with: exc_kill=1 with a CC write of alu_y=-1 -> sf stays 0; same-cycle ifun=9 -> cnd=0, cc_err=1, cnd_valid=1.
REQ-037 SHALL be checked with: rst=1 in the same cycle as a CC write of alu_y=0 with alu_carry=1 and cond_req -> zf=1, cf=0, cnd_valid=0 on the next edge.
